// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown front-end and countdown stage.
// Holds the setter state encoding, the step-size table and the saturating step helper.
package countdown_pkg;

  localparam int TIME_W = 16;

  typedef enum logic [1:0] {
    EDIT    = 2'd0,
    LAUNCH  = 2'd1,
    RUNNING = 2'd2
  } setter_state_e;

  localparam logic [TIME_W-1:0] STEP_LUT [4] = '{16'd1, 16'd10, 16'd100, 16'd1000};

  // One step up or down, clamped to [0, max_t]; the sum is taken one bit wider so it cannot wrap.
  function automatic logic [TIME_W-1:0] sat_step(
    input logic [TIME_W-1:0] cur,
    input logic [TIME_W-1:0] step,
    input logic              up,
    input logic [TIME_W-1:0] max_t
  );
    logic [TIME_W:0] sum;
    sum = {1'b0, cur} + {1'b0, step};
    if (up) begin
      return (sum > {1'b0, max_t}) ? max_t : sum[TIME_W-1:0];
    end
    return (cur < step) ? '0 : (cur - step);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser followed by a stability counter; the debounced level only
// follows the raw button once it has read the same value for DEBOUNCE_CYCLES samples.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic             rise_q;
  logic             rise_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Any sample that agrees with the current level restarts the stability count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_level = level_q;
  assign btn_rise  = rise_q;

endmodule

// File: rtl/countdown_time_setter.sv
// Operator front-end for the countdown: edits a saturating preset with up/down buttons
// (with auto-repeat), then fires a one-cycle start and locks editing until stop returns.
module countdown_time_setter
  import countdown_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000,
  parameter int MAX_TIME        = 9999,
  parameter int DEFAULT_TIME    = 60
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_confirm,
  input  logic [1:0]        step_sel,
  input  logic              stop,
  output logic [TIME_W-1:0] time_out,
  output logic              start,
  output logic              busy
);

  localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [RPT_W-1:0] RPT_FIRE   = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);

  // Bit order: 0 = up, 1 = down, 2 = confirm.
  logic [2:0] btn_raw;
  logic [2:0] btn_lvl;
  logic [2:0] btn_rise;

  assign btn_raw = {btn_confirm, btn_down, btn_up};

  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_raw  (btn_raw[gi]),
      .btn_level(btn_lvl[gi]),
      .btn_rise (btn_rise[gi])
    );
  end

  setter_state_e     state_q;
  logic [TIME_W-1:0] time_q;
  logic [TIME_W-1:0] time_d;
  logic              start_q;
  logic              busy_q;
  logic [RPT_W-1:0]  rpt_cnt_q;
  logic [RPT_W-1:0]  rpt_cnt_d;

  logic in_edit;
  logic up_held;
  logic dn_held;
  logic single_held;
  logic press_evt;
  logic rpt_fire;
  logic step_evt;
  logic conf_evt;

  assign in_edit     = (state_q == EDIT);
  assign up_held     = btn_lvl[0] & ~btn_lvl[1];
  assign dn_held     = btn_lvl[1] & ~btn_lvl[0];
  assign single_held = up_held | dn_held;
  assign press_evt   = (btn_rise[0] & up_held) | (btn_rise[1] & dn_held);
  assign rpt_fire    = (rpt_cnt_q == RPT_FIRE);
  assign step_evt    = in_edit & single_held & (press_evt | rpt_fire);
  assign conf_evt    = in_edit & btn_rise[2] & btn_lvl[2] & ~step_evt & (time_q != '0);

  // The repeat counter only starts on a fresh press seen in EDIT, so a button still held
  // from before a countdown cannot auto-repeat once editing resumes.
  always_comb begin
    rpt_cnt_d = '0;
    if (in_edit && single_held) begin
      if (rpt_fire) begin
        rpt_cnt_d = RPT_RELOAD;
      end else if (press_evt || (rpt_cnt_q != '0)) begin
        rpt_cnt_d = rpt_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    time_d = time_q;
    if (step_evt) begin
      time_d = sat_step(time_q, STEP_LUT[step_sel], up_held, TIME_W'(MAX_TIME));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EDIT;
      time_q    <= TIME_W'(DEFAULT_TIME);
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      rpt_cnt_q <= '0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
      case (state_q)
        EDIT: begin
          time_q <= time_d;
          if (conf_evt) begin
            state_q <= LAUNCH;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        LAUNCH: begin
          state_q <= RUNNING;
          start_q <= 1'b0;
        end
        RUNNING: begin
          if (stop) begin
            state_q <= EDIT;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= EDIT;
          start_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign time_out = time_q;
  assign start    = start_q;
  assign busy     = busy_q;

endmodule
